// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU sequencing stage.
//   LARGURA  : datapath width of operands/result (must match the mux width)
//   SEL_W    : opcode/select width
//   estado_t : sequencing FSM states
//   op_t     : names of the 8 mux slots
package alu_pkg;

    localparam int unsigned LARGURA = 4;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        OCIOSO,
        EXECUTA,
        PRONTO
    } estado_t;

    typedef enum logic [SEL_W-1:0] {
        OP_SOMA,
        OP_SOMA_ALT,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_NOT
    } op_t;

endpackage

// File: rtl/alu_controle_if.sv
// Request/result bus between the requester, the ALU mux and alu_controle.
//   request : in_valid/in_ready, a, b, operacao, usar_acc, limpa_acc
//   to mux  : op_a, op_b, selecao ; from mux : saida_mux
//   result  : resultado, zero, negativo, out_valid/out_ready, contador_ops
interface alu_controle_if #(
    parameter int unsigned CNT_W = 8
);
    import alu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [LARGURA-1:0] a;
    logic [LARGURA-1:0] b;
    logic [SEL_W-1:0]   operacao;
    logic               usar_acc;
    logic               limpa_acc;
    logic [LARGURA-1:0] op_a;
    logic [LARGURA-1:0] op_b;
    logic [SEL_W-1:0]   selecao;
    logic [LARGURA-1:0] saida_mux;
    logic [LARGURA-1:0] resultado;
    logic               zero;
    logic               negativo;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   contador_ops;

    // Requester side (also supplies the mux output)
    modport master (
        output in_valid, a, b, operacao, usar_acc, limpa_acc, saida_mux, out_ready,
        input  in_ready, op_a, op_b, selecao, resultado, zero, negativo, out_valid,
               contador_ops
    );

    // alu_controle side
    modport slave (
        input  in_valid, a, b, operacao, usar_acc, limpa_acc, saida_mux, out_ready,
        output in_ready, op_a, op_b, selecao, resultado, zero, negativo, out_valid,
               contador_ops
    );

endinterface

// File: rtl/alu_controle.sv
// Sequencing and result stage around the ALU 8:1 operation mux.
// Registers a request (operands + opcode, operand A optionally from the
// accumulator), lets the external mux settle for one cycle, captures the
// result with zero/negative flags and holds it until the consumer takes it.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_controle_if.slave (request, mux operands/select, result)
module alu_controle
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    alu_controle_if.slave bus
);

    estado_t            r_estado;
    estado_t            w_prox_estado;
    logic               w_in_ready;
    logic               w_aceita;
    logic               w_entrega;

    logic [LARGURA-1:0] r_op_a;
    logic [LARGURA-1:0] r_op_b;
    logic [SEL_W-1:0]   r_selecao;
    logic [LARGURA-1:0] r_resultado;
    logic               r_zero;
    logic               r_negativo;
    logic               r_out_valid;
    logic [LARGURA-1:0] r_acc;
    logic [CNT_W-1:0]   r_contador;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next state and handshake decode; PRONTO accepts a new request only
    // in the same cycle its result is taken.
    always_comb begin
        w_prox_estado = r_estado;
        w_in_ready    = 1'b0;
        w_entrega     = 1'b0;
        case (r_estado)
            OCIOSO: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_prox_estado = EXECUTA;
                end
            end
            EXECUTA: begin
                w_prox_estado = PRONTO;
            end
            PRONTO: begin
                if (bus.out_ready) begin
                    w_in_ready    = 1'b1;
                    w_entrega     = 1'b1;
                    w_prox_estado = bus.in_valid ? EXECUTA : OCIOSO;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
        w_aceita = bus.in_valid && w_in_ready;
    end

    // Datapath: operand latch on accept, result capture in EXECUTA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_selecao   <= '0;
            r_resultado <= '0;
            r_zero      <= 1'b1;
            r_negativo  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_contador  <= '0;
        end else begin
            if (w_aceita) begin
                // Uses the pre-clear accumulator even if limpa_acc is high now
                r_op_a    <= bus.usar_acc ? r_acc : bus.a;
                r_op_b    <= bus.b;
                r_selecao <= bus.operacao;
            end

            if (r_estado == EXECUTA) begin
                r_resultado <= bus.saida_mux;
                r_zero      <= (bus.saida_mux == '0);
                r_negativo  <= bus.saida_mux[LARGURA-1];
                r_out_valid <= 1'b1;
            end else if (w_entrega) begin
                r_out_valid <= 1'b0;
                r_contador  <= r_contador + CNT_W'(1);
            end

            // Clear wins over the capture of a new result
            if (bus.limpa_acc) begin
                r_acc <= '0;
            end else if (r_estado == EXECUTA) begin
                r_acc <= bus.saida_mux;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.op_a         = r_op_a;
    assign bus.op_b         = r_op_b;
    assign bus.selecao      = r_selecao;
    assign bus.resultado    = r_resultado;
    assign bus.zero         = r_zero;
    assign bus.negativo     = r_negativo;
    assign bus.out_valid    = r_out_valid;
    assign bus.contador_ops = r_contador;

endmodule

// File: tb/tb_alu_controle.sv
// Bench for alu_controle: a behavioural mux stands in for the functional
// units; a transaction-level model predicts every output each cycle.
module tb_alu_controle;
    import alu_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst_n;

    alu_controle_if #(.CNT_W(CNT_W)) u_bus ();

    alu_controle #(.CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 8 functional-unit slots, plain 4-bit arithmetic
    function automatic logic [3:0] mux_ref(input logic [2:0] s, input logic [3:0] x,
                                           input logic [3:0] y);
        case (s)
            3'd0, 3'd1: return 4'((x + y) % 16);
            3'd2:       return 4'((x + 16 - y) % 16);
            3'd3:       return x & y;
            3'd4:       return x | y;
            3'd5:       return x ^ y;
            3'd6:       return 4'((x * 2) % 16);
            default:    return ~x;
        endcase
    endfunction

    always_comb u_bus.saida_mux = mux_ref(u_bus.selecao, u_bus.op_a, u_bus.op_b);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model: m_pend = request accepted, result not yet captured;
    // m_valid = captured result waiting for the consumer.
    bit         m_pend;
    bit         m_valid;
    logic [3:0] m_opa, m_opb, m_res, m_acc;
    logic [2:0] m_sel;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_pend = 0; m_valid = 0;
        m_opa = 0; m_opb = 0; m_sel = 0; m_res = 0; m_acc = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        chk("op_a",         32'(u_bus.op_a),         32'(m_opa));
        chk("op_b",         32'(u_bus.op_b),         32'(m_opb));
        chk("selecao",      32'(u_bus.selecao),      32'(m_sel));
        chk("resultado",    32'(u_bus.resultado),    32'(m_res));
        chk("zero",         32'(u_bus.zero),         32'(m_res == 4'd0));
        chk("negativo",     32'(u_bus.negativo),     32'(m_res[3]));
        chk("out_valid",    32'(u_bus.out_valid),    32'(m_valid));
        chk("contador_ops", 32'(u_bus.contador_ops), 32'(m_cnt));
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic ciclo(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                         input logic [2:0] iop, input logic usa, input logic limpa,
                         input logic ordy);
        bit         exp_rdy;
        bit         aceita;
        bit         captura;
        logic [3:0] acc_pre;
        check_outputs();
        u_bus.in_valid  = v;
        u_bus.a         = ia;
        u_bus.b         = ib;
        u_bus.operacao  = iop;
        u_bus.usar_acc  = usa;
        u_bus.limpa_acc = limpa;
        u_bus.out_ready = ordy;
        exp_rdy = !m_pend && (!m_valid || ordy);
        #1;
        chk("in_ready", 32'(u_bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        acc_pre = m_acc;
        aceita  = v && exp_rdy;
        captura = m_pend;
        if (m_valid && ordy) begin
            m_valid = 0;
            m_cnt   = m_cnt + 8'd1;
        end
        if (captura) begin
            m_res   = mux_ref(m_sel, m_opa, m_opb);
            m_valid = 1;
        end
        if (limpa) m_acc = 4'd0;
        else if (captura) m_acc = m_res;
        if (aceita) begin
            m_opa = usa ? acc_pre : ia;
            m_opb = ib;
            m_sel = iop;
        end
        m_pend = aceita;
        @(negedge clk);
    endtask

    task automatic ocioso(input logic ordy);
        ciclo(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        rst_n = 1'b0;
        u_bus.in_valid = 0; u_bus.a = 0; u_bus.b = 0; u_bus.operacao = 0;
        u_bus.usar_acc = 0; u_bus.limpa_acc = 0; u_bus.out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_in_ready", 32'(u_bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Single op: 3 + 5 in slot 1
        ciclo(1'b1, 4'h3, 4'h5, 3'b001, 1'b0, 1'b0, 1'b0);
        chk("single_sel", 32'(u_bus.selecao), 32'd1);
        chk("single_vld_early", 32'(u_bus.out_valid), 32'd0);
        ocioso(1'b0);
        chk("single_res", 32'(u_bus.resultado), 32'h8);
        chk("single_vld", 32'(u_bus.out_valid), 32'd1);
        chk("single_zero", 32'(u_bus.zero), 32'd0);
        chk("single_neg", 32'(u_bus.negativo), 32'd1);

        // Backpressure: requests ignored, result frozen
        for (int i = 0; i < 5; i++)
            ciclo(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b0);
        chk("bp_res", 32'(u_bus.resultado), 32'h8);
        ocioso(1'b1);
        chk("bp_cnt", 32'(u_bus.contador_ops), 32'd1);

        // Back-to-back: four requests, one result every two cycles
        for (int i = 0; i < 8; i++)
            ciclo(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1);
        ocioso(1'b1);
        chk("b2b_cnt", 32'(u_bus.contador_ops), 32'd5);

        // Accumulator chaining: (2+3) then acc+4
        ciclo(1'b1, 4'd2, 4'd3, 3'd0, 1'b0, 1'b0, 1'b1);
        ocioso(1'b1);
        ciclo(1'b1, 4'd7, 4'd4, 3'd0, 1'b1, 1'b0, 1'b1);
        ocioso(1'b1);
        chk("acc_res", 32'(u_bus.resultado), 32'h9);
        ocioso(1'b1);

        // Same chain with a clear in between
        ciclo(1'b1, 4'd2, 4'd3, 3'd0, 1'b0, 1'b0, 1'b1);
        ocioso(1'b1);
        ciclo(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        ciclo(1'b1, 4'd7, 4'd4, 3'd0, 1'b1, 1'b0, 1'b1);
        ocioso(1'b1);
        chk("acc_clr_res", 32'(u_bus.resultado), 32'h4);
        ocioso(1'b1);

        // Zero result
        ciclo(1'b1, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        ocioso(1'b1);
        chk("zero_res", 32'(u_bus.zero), 32'd1);
        ocioso(1'b1);

        // Random traffic, long enough for the counter to wrap
        for (int i = 0; i < 1500; i++)
            ciclo(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) != 0));

        // Reset in the middle of EXECUTA
        ocioso(1'b1);
        ocioso(1'b1);
        ciclo(1'b1, 4'd6, 4'd7, 3'd2, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res", 32'(u_bus.resultado), 32'd0);
        chk("mid_rst_zero", 32'(u_bus.zero), 32'd1);
        chk("mid_rst_vld", 32'(u_bus.out_valid), 32'd0);
        chk("mid_rst_rdy", 32'(u_bus.in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(u_bus.contador_ops), 32'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++)
            ciclo(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
